// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   state_t        loader FSM state encoding
//   WORD_W         width of one host / frame-memory word
//   FRAME_WORDS    words per scheduler frame; image lengths are whole frames
//   MAGIC_DEFAULT  sync word that opens every image
//   len_valid()    header length check (non-zero, fits memory, whole frames)
package prog_loader_pkg;

  localparam int WORD_W      = 16;
  localparam int FRAME_WORDS = 16;
  localparam logic [WORD_W-1:0] MAGIC_DEFAULT = 16'hA5C3;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN,
    DATA,
    CSUM,
    FILL,
    DONE,
    ERR
  } state_t;

  function automatic logic len_valid(input logic [WORD_W-1:0] n, input int depth);
    return (n != '0) && (int'({16'd0, n}) <= depth) &&
           (n[$clog2(FRAME_WORDS)-1:0] == '0);
  endfunction

endpackage

// File: rtl/prog_loader_xor.sv
// xor_csum: running XOR of accepted data words.
//   clk, reset  clock and synchronous active-high reset
//   clear       zero the accumulator (takes priority over en)
//   en          fold din into the accumulator
//   din         data word
//   sum         current accumulator value
module xor_csum
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a program image from the host link and writes it into
// the frame memory the scheduler executes from.
// Image format: MAGIC, N, then N data words (plus one checksum word when
// PROG_LOADER_CSUM_EN is defined). Memory past word N-1 is zero-filled.
//   clk, reset    clock and synchronous active-high reset
//   start         load request pulse (honoured in IDLE and ERR)
//   in_valid      host word valid
//   in_data       host word
//   in_ready      loader accepts in_data this cycle
//   frames_out    flattened frame memory, word k at [16k+15:16k]
//   prog_loading  scheduler hold while an image is in flight or invalid
//   load_done     one-cycle pulse when the image is ready to run
//   load_err      image error, held until the next start
//   words_loaded  data words written in the current load
// Build option: PROG_LOADER_CSUM_EN adds a trailing XOR checksum word.
//
// state | meaning
// IDLE  | waiting for start
// SYNC  | discarding words until MAGIC
// LEN   | reading and validating the length word N
// DATA  | writing N data words
// CSUM  | comparing the checksum word (checksum build only)
// FILL  | zeroing memory from N to DATA_DEPTH-1
// DONE  | one-cycle completion pulse
// ERR   | bad image, scheduler held until start
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                DATA_DEPTH = 1024,
  parameter int                ADDR_W     = 10,
  parameter logic [WORD_W-1:0] MAGIC      = MAGIC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_data,
  output logic                       in_ready,
  output logic [DATA_DEPTH*WORD_W-1:0] frames_out,
  output logic                       prog_loading,
  output logic                       load_done,
  output logic                       load_err,
  output logic [ADDR_W:0]            words_loaded
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DATA_DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DATA_DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   wr_addr, wr_addr_nxt;
  logic [ADDR_W:0]   len, len_nxt;
  logic [ADDR_W:0]   words_nxt;
  logic              accept;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem [DATA_DEPTH];

  assign accept = in_valid && in_ready;

`ifdef PROG_LOADER_CSUM_EN
  logic              csum_clear;
  logic              csum_en;
  logic [WORD_W-1:0] csum_sum;

  xor_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clear (csum_clear),
    .en    (csum_en),
    .din   (in_data),
    .sum   (csum_sum)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_addr      <= '0;
      len          <= '0;
      words_loaded <= '0;
    end else begin
      state        <= state_nxt;
      wr_addr      <= wr_addr_nxt;
      len          <= len_nxt;
      words_loaded <= words_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wr_addr_nxt  = wr_addr;
    len_nxt      = len;
    words_nxt    = words_loaded;
    mem_we       = 1'b0;
    mem_wdata    = in_data;
    in_ready     = 1'b0;
    prog_loading = 1'b1;
    load_done    = 1'b0;
    load_err     = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    csum_clear   = 1'b0;
    csum_en      = 1'b0;
`endif
    case (state)
      IDLE: begin
        prog_loading = 1'b0;
        if (start) begin
          state_nxt = SYNC;
          words_nxt = '0;
        end
      end
      SYNC: begin
        in_ready = 1'b1;
        if (accept && in_data == MAGIC) begin
          state_nxt = LEN;
`ifdef PROG_LOADER_CSUM_EN
          csum_clear = 1'b1;
`endif
        end
      end
      LEN: begin
        in_ready = 1'b1;
        if (accept) begin
          if (len_valid(in_data, DATA_DEPTH)) begin
            len_nxt     = in_data[ADDR_W:0];
            wr_addr_nxt = '0;
            state_nxt   = DATA;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (accept) begin
          mem_we      = 1'b1;
          wr_addr_nxt = wr_addr + ONE_L;
          words_nxt   = words_loaded + ONE_L;
`ifdef PROG_LOADER_CSUM_EN
          csum_en = 1'b1;
          if (wr_addr + ONE_L == len) state_nxt = CSUM;
`else
          if (wr_addr + ONE_L == len) state_nxt = (len == DEPTH_L) ? DONE : FILL;
`endif
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        if (accept) begin
          if (in_data == csum_sum) state_nxt = (len == DEPTH_L) ? DONE : FILL;
          else                     state_nxt = ERR;
        end
      end
`endif
      FILL: begin
        mem_we      = 1'b1;
        mem_wdata   = '0;
        wr_addr_nxt = wr_addr + ONE_L;
        if (wr_addr == LAST_L) state_nxt = DONE;
      end
      DONE: begin
        prog_loading = 1'b0;
        load_done    = 1'b1;
        state_nxt    = IDLE;
      end
      ERR: begin
        load_err = 1'b1;
        if (start) begin
          state_nxt = SYNC;
          words_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register array rather than RAM: the scheduler reads every word in parallel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DATA_DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[wr_addr[ADDR_W-1:0]] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < DATA_DEPTH; k++) begin : g_frames
    assign frames_out[k*WORD_W +: WORD_W] = mem[k];
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int DEPTH = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [15:0]       in_data = '0;
  logic              in_ready;
  logic [DEPTH*16-1:0] frames_out;
  logic              prog_loading;
  logic              load_done;
  logic              load_err;
  logic [10:0]       words_loaded;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  prog_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .frames_out   (frames_out),
    .prog_loading (prog_loading),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic send_word(input logic [15:0] w);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout word=%h actual in_ready=0 required 1", w);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit hold_ok);
    cycles  = 0;
    hold_ok = 1'b1;
    while (!load_done && cycles < budget) begin
      if (!prog_loading) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic check_mem(input string name);
    int shown = 0;
    logic [15:0] exp_w;
    vectors++;
    if (exp_q.size() !== DEPTH) begin
      miscompares++;
      $display("FAIL %s_qsize actual %0d required %0d", name, exp_q.size(), DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (exp_q.size() == 0) break;
      exp_w = exp_q.pop_front();
      vectors++;
      if (frames_out[k*16 +: 16] !== exp_w) begin
        miscompares++;
        if (shown < 8) begin
          $display("FAIL %s_mem[%0d] actual %h required %h", name, k, frames_out[k*16 +: 16], exp_w);
          shown++;
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, prog_loading, load_done, load_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags actual %b required 0000", {in_ready, prog_loading, load_done, load_err});
    end
    vectors++;
    if (words_loaded !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_words actual %0d required 0", words_loaded);
    end
    vectors++;
    if (frames_out !== '0) begin
      miscompares++;
      $display("FAIL reset_mem actual nonzero required all zero");
    end
    reset = 1'b0;
  endtask

  task automatic finish_load(input string name, input int exp_cycles, input int exp_words);
    int cycles;
    bit hold_ok;
    wait_done(4000, cycles, hold_ok);
    vectors++;
    if (load_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done_timeout actual load_done=%b required 1", name, load_done);
    end
    vectors++;
    if (cycles != exp_cycles) begin
      miscompares++;
      $display("FAIL %s_done_latency actual %0d required %0d", name, cycles, exp_cycles);
    end
    vectors++;
    if (!hold_ok || prog_loading !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_hold actual hold_ok=%b loading_at_done=%b required 1/0", name, hold_ok, prog_loading);
    end
    vectors++;
    if (words_loaded !== 11'(exp_words)) begin
      miscompares++;
      $display("FAIL %s_words actual %0d required %0d", name, words_loaded, exp_words);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({load_done, prog_loading, in_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s_after_done actual %b required 000", name, {load_done, prog_loading, in_ready});
    end
    check_mem(name);
  endtask

  task automatic test_basic();
    pulse_start();
    vectors++;
    if (prog_loading !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_start actual loading=%b ready=%b required 1/1", prog_loading, in_ready);
    end
    send_word(16'hA5C3);
    send_word(16'h0020);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(16'h1000 + 16'(i));
      send_word(16'h1000 + 16'(i));
    end
    for (int i = 32; i < DEPTH; i++) exp_q.push_back(16'h0000);
    finish_load("basic", 992, 32);
  endtask

  task automatic test_sync_junk();
    logic [15:0] w;
    pulse_start();
    send_word(16'h1234);
    send_word(16'hFFFF);
    vectors++;
    if (in_ready !== 1'b1 || load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL junk_still_sync actual ready=%b err=%b required 1/0", in_ready, load_err);
    end
    send_word(16'hA5C3);
    send_word(16'h0010);
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      send_word(w);
    end
    for (int i = 16; i < DEPTH; i++) exp_q.push_back(16'h0000);
    finish_load("junk", DEPTH - 16, 16);
  endtask

  task automatic test_bad_len();
    logic [15:0] lens [3];
    lens[0] = 16'h0011;
    lens[1] = 16'h0000;
    lens[2] = 16'h0410;
    for (int j = 0; j < 3; j++) begin
      pulse_start();
      send_word(16'hA5C3);
      send_word(lens[j]);
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if ({load_err, prog_loading, in_ready, load_done} !== 4'b1100) begin
        miscompares++;
        $display("FAIL badlen_%h_err actual err/load/ready/done=%b required 1100", lens[j],
                 {load_err, prog_loading, in_ready, load_done});
      end
      pulse_start();
      vectors++;
      if (load_err !== 1'b0 || in_ready !== 1'b1 || prog_loading !== 1'b1) begin
        miscompares++;
        $display("FAIL badlen_%h_restart actual err=%b ready=%b loading=%b required 0/1/1", lens[j],
                 load_err, in_ready, prog_loading);
      end
      do_reset();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    pulse_start();
    send_word(16'hA5C3);
    send_word(16'h0400);
    for (int i = 0; i < DEPTH; i++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      send_word(w);
      if (i < DEPTH - 1) @(posedge clk);
    end
    finish_load("full", 0, DEPTH);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_word(16'hA5C3);
    send_word(16'h0020);
    for (int i = 0; i < 7; i++) send_word(16'hBEE0 + 16'(i));
    vectors++;
    if (words_loaded !== 11'd7) begin
      miscompares++;
      $display("FAIL midrst_words_before actual %0d required 7", words_loaded);
    end
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, prog_loading, load_done, load_err} !== 4'b0000 || words_loaded !== 11'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs actual flags=%b words=%0d required 0000/0",
               {in_ready, prog_loading, load_done, load_err}, words_loaded);
    end
    vectors++;
    if (frames_out !== '0) begin
      miscompares++;
      $display("FAIL midrst_mem actual nonzero required all zero");
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0 || prog_loading !== 1'b0 || frames_out !== '0) begin
      miscompares++;
      $display("FAIL midrst_idle actual ready=%b loading=%b required 0/0 with mem zero", in_ready, prog_loading);
    end
    in_valid = 1'b0;
  endtask

`ifdef PROG_LOADER_CSUM_EN
  task automatic test_csum();
    logic [15:0] sum;
    int cycles;
    bit hold_ok;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      send_word(16'hA5C3);
      send_word(16'h0010);
      sum = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        sum = sum ^ 16'h0001;
        exp_q.push_back(16'h0001);
        send_word(16'h0001);
      end
      for (int i = 16; i < DEPTH; i++) exp_q.push_back(16'h0000);
      if (pass == 0) begin
        send_word(sum);
        finish_load("csum_ok", DEPTH - 16, 16);
      end else begin
        exp_q.delete();
        send_word(sum ^ 16'h0001);
        wait_done(20, cycles, hold_ok);
        vectors++;
        if (load_err !== 1'b1 || load_done !== 1'b0 || prog_loading !== 1'b1) begin
          miscompares++;
          $display("FAIL csum_bad actual err=%b done=%b loading=%b required 1/0/1", load_err, load_done, prog_loading);
        end
        do_reset();
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_sync_junk();
    test_bad_len();
    test_back_to_back();
    test_reset_mid();
`ifdef PROG_LOADER_CSUM_EN
    test_csum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
